// File: rtl/controle_bloqueio_if.sv
// Password-result pulses into the lockout scheduler, keypad/display controls out of it.
// segundos_rest exists only when SEGUNDOS_RESTANTES_EN is defined.
interface controle_bloqueio_if;
   logic       senha_ok;
   logic       senha_erro;
   logic       teclado_en;
   logic       inoperante;
   logic       bloqueado;
   logic [5:0] hifen_mask;
   logic [2:0] num_erros;
   logic       fim_bloqueio;
`ifdef SEGUNDOS_RESTANTES_EN
   logic [5:0] segundos_rest;
`endif

   modport master (
      output senha_ok, senha_erro,
`ifdef SEGUNDOS_RESTANTES_EN
      input  segundos_rest,
`endif
      input  teclado_en, inoperante, bloqueado, hifen_mask, num_erros, fim_bloqueio
   );

   modport slave (
      input  senha_ok, senha_erro,
`ifdef SEGUNDOS_RESTANTES_EN
      output segundos_rest,
`endif
      output teclado_en, inoperante, bloqueado, hifen_mask, num_erros, fim_bloqueio
   );
endinterface

// File: rtl/controle_bloqueio.sv
// Wrong-password penalty/lockout scheduler; all outputs registered, one cycle after the input edge.
// SEGUNDOS_RESTANTES_EN adds the segundos_rest countdown output.
module controle_bloqueio #(
   parameter int UM_SEGUNDO = 1000,
   parameter int MAX_ERROS  = 5,
   parameter int T_ERRO_S   = 1,
   parameter int T_BLOQ_S   = 30
) (
   input  logic               clk,
   input  logic               rst,
   controle_bloqueio_if.slave bus
);
   localparam int               CYC_W    = (UM_SEGUNDO > 1) ? $clog2(UM_SEGUNDO) : 1;
   localparam logic [CYC_W-1:0] CYC_MAX  = CYC_W'(UM_SEGUNDO - 1);
   localparam logic [2:0]       MAX_E    = 3'(MAX_ERROS);
   localparam logic [5:0]       ERRO_FIM = 6'(T_ERRO_S - 1);
   localparam logic [5:0]       BLOQ_FIM = 6'(T_BLOQ_S - 1);

   typedef enum logic [1:0] {IDLE, PENALTY, LOCKOUT} estado_t;

   estado_t          estado_q;
   logic [CYC_W-1:0] ciclo_q;
   logic [5:0]       seg_q;
   logic             teclado_q, inop_q, bloq_q, fim_q;
   logic [5:0]       mask_q;
   logic [2:0]       erros_q;
   logic [2:0]       erros_d;
   logic [5:0]       mask_d;
   logic             wrap_d;
`ifdef SEGUNDOS_RESTANTES_EN
   logic [5:0]       rest_q;
`endif

   assign erros_d = erros_q + 3'd1;
   assign mask_d  = (6'd1 << erros_d) - 6'd1;
   assign wrap_d  = (ciclo_q == CYC_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q  <= IDLE;
         ciclo_q   <= '0;
         seg_q     <= '0;
         teclado_q <= 1'b1;
         inop_q    <= 1'b0;
         bloq_q    <= 1'b0;
         fim_q     <= 1'b0;
         mask_q    <= '0;
         erros_q   <= '0;
`ifdef SEGUNDOS_RESTANTES_EN
         rest_q    <= '0;
`endif
      end else begin
         fim_q <= 1'b0;
         // Timebase runs only while inoperative; exits below override it with a clear.
         if (estado_q != IDLE) begin
            if (wrap_d) begin
               ciclo_q <= '0;
               seg_q   <= seg_q + 6'd1;
`ifdef SEGUNDOS_RESTANTES_EN
               rest_q  <= rest_q - 6'd1;
`endif
            end else begin
               ciclo_q <= ciclo_q + 1'b1;
            end
         end
         case (estado_q)
            IDLE: begin
               // Simultaneous ok+erro falls into this branch: treated as an error.
               if (bus.senha_erro) begin
                  ciclo_q   <= '0;
                  seg_q     <= '0;
                  teclado_q <= 1'b0;
                  inop_q    <= 1'b1;
                  if (erros_d == MAX_E) begin
                     estado_q <= LOCKOUT;
                     bloq_q   <= 1'b1;
                     mask_q   <= 6'h3F;
                     erros_q  <= MAX_E;
`ifdef SEGUNDOS_RESTANTES_EN
                     rest_q   <= 6'(T_BLOQ_S);
`endif
                  end else begin
                     estado_q <= PENALTY;
                     mask_q   <= mask_d;
                     erros_q  <= erros_d;
`ifdef SEGUNDOS_RESTANTES_EN
                     rest_q   <= 6'(T_ERRO_S);
`endif
                  end
               end else if (bus.senha_ok) begin
                  erros_q <= '0;
                  mask_q  <= '0;
               end
            end
            PENALTY: begin
               if (wrap_d && (seg_q == ERRO_FIM)) begin
                  estado_q  <= IDLE;
                  ciclo_q   <= '0;
                  seg_q     <= '0;
                  teclado_q <= 1'b1;
                  inop_q    <= 1'b0;
`ifdef SEGUNDOS_RESTANTES_EN
                  rest_q    <= '0;
`endif
               end
            end
            LOCKOUT: begin
               if (wrap_d && (seg_q == BLOQ_FIM)) begin
                  estado_q  <= IDLE;
                  ciclo_q   <= '0;
                  seg_q     <= '0;
                  teclado_q <= 1'b1;
                  inop_q    <= 1'b0;
                  bloq_q    <= 1'b0;
                  fim_q     <= 1'b1;
                  mask_q    <= '0;
                  erros_q   <= '0;
`ifdef SEGUNDOS_RESTANTES_EN
                  rest_q    <= '0;
`endif
               end
            end
            default: estado_q <= IDLE;
         endcase
      end
   end

   assign bus.teclado_en   = teclado_q;
   assign bus.inoperante   = inop_q;
   assign bus.bloqueado    = bloq_q;
   assign bus.hifen_mask   = mask_q;
   assign bus.num_erros    = erros_q;
   assign bus.fim_bloqueio = fim_q;
`ifdef SEGUNDOS_RESTANTES_EN
   assign bus.segundos_rest = rest_q;
`endif
endmodule

// File: tb/tb_controle_bloqueio.sv
// Bench for controle_bloqueio: directed plan plus random pulses, checked against a
// cycle-countdown reference model every cycle.
module tb_controle_bloqueio;
   localparam int UM     = 1000;
   localparam int MAXE   = 5;
   localparam int T_ERRO = 1;
   localparam int T_BLOQ = 30;

   logic clk = 1'b0;
   logic rst = 1'b1;
   controle_bloqueio_if bus_if ();

   controle_bloqueio #(
      .UM_SEGUNDO (UM),
      .MAX_ERROS  (MAXE),
      .T_ERRO_S   (T_ERRO),
      .T_BLOQ_S   (T_BLOQ)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 penalty, 2 lockout; m_left = cycles still to serve.
   int m_mode = 0, m_err = 0, m_left = 0, m_el = 0;
   bit m_fim = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0; m_err = 0; m_left = 0; m_el = 0; m_fim = 1'b0;
      end else begin
         m_fim = 1'b0;
         if (m_mode == 0) begin
            if (bus_if.senha_erro) begin
               m_err++;
               m_el = 0;
               if (m_err >= MAXE) begin
                  m_mode = 2; m_left = T_BLOQ * UM;
               end else begin
                  m_mode = 1; m_left = T_ERRO * UM;
               end
            end else if (bus_if.senha_ok) begin
               m_err = 0;
            end
         end else begin
            m_left--;
            m_el++;
            if (m_left == 0) begin
               if (m_mode == 2) begin
                  m_err = 0;
                  m_fim = 1'b1;
               end
               m_mode = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [5:0]  e_mask;
      logic [12:0] e_vec, a_vec;
      if (chk_en) begin
         e_mask = (m_mode == 2) ? 6'h3F : 6'((1 << m_err) - 1);
         e_vec  = {m_mode == 0, m_mode != 0, m_mode == 2, e_mask, 3'(m_err), m_fim};
         a_vec  = {bus_if.teclado_en, bus_if.inoperante, bus_if.bloqueado,
                   bus_if.hifen_mask, bus_if.num_erros, bus_if.fim_bloqueio};
         chk("model_outs", 32'(a_vec), 32'(e_vec));
`ifdef SEGUNDOS_RESTANTES_EN
         chk("model_seg", 32'(bus_if.segundos_rest),
             (m_mode == 0) ? 32'd0 : 32'(((m_mode == 2) ? T_BLOQ : T_ERRO) - m_el / UM));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input bit ok, input bit erro);
      bus_if.senha_ok   = ok;
      bus_if.senha_erro = erro;
      tick();
      bus_if.senha_ok   = 1'b0;
      bus_if.senha_erro = 1'b0;
   endtask

   task automatic wait_idle(input int bound, output int cnt);
      cnt = 0;
      while (bus_if.teclado_en !== 1'b1 && cnt < bound) begin
         tick();
         cnt++;
      end
   endtask

   int         cnt, nfim;
   logic [5:0] exp_mask [4] = '{6'h01, 6'h03, 6'h07, 6'h0F};

   initial begin
      bus_if.senha_ok   = 1'b0;
      bus_if.senha_erro = 1'b0;

      // Reset held for three cycles.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_teclado", 32'(bus_if.teclado_en), 32'd1);
      chk("rst_mask",    32'(bus_if.hifen_mask), 32'h00);
      chk("rst_erros",   32'(bus_if.num_erros),  32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;
      tick();

      // Four penalised errors, each after the previous penalty.
      for (int i = 0; i < 4; i++) begin
         send(1'b0, 1'b1);
         chk("pen_teclado", 32'(bus_if.teclado_en), 32'd0);
         chk("pen_mask",    32'(bus_if.hifen_mask), 32'(exp_mask[i]));
         wait_idle(5000, cnt);
         chk("pen_len",     32'(cnt), 32'(T_ERRO * UM));
         chk("pen_mask_after", 32'(bus_if.hifen_mask), 32'(exp_mask[i]));
      end
      chk("erros_4", 32'(bus_if.num_erros), 32'd4);

      // Fifth error: lockout, pulses ignored throughout.
      send(1'b0, 1'b1);
      chk("lock_bloq", 32'(bus_if.bloqueado),  32'd1);
      chk("lock_mask", 32'(bus_if.hifen_mask), 32'h3F);
`ifdef SEGUNDOS_RESTANTES_EN
      chk("lock_seg_entry", 32'(bus_if.segundos_rest), 32'd30);
`endif
      cnt  = 0;
      nfim = 0;
      while (bus_if.teclado_en !== 1'b1 && cnt < 40000) begin
         bus_if.senha_erro = (cnt > 0) && (cnt % 4000 == 0);
         bus_if.senha_ok   = (cnt % 4000 == 2000);
         tick();
         cnt++;
         if (bus_if.fim_bloqueio === 1'b1) nfim++;
`ifdef SEGUNDOS_RESTANTES_EN
         if (cnt == 1000) chk("lock_seg_1s", 32'(bus_if.segundos_rest), 32'd29);
`endif
      end
      bus_if.senha_erro = 1'b0;
      bus_if.senha_ok   = 1'b0;
      chk("lock_len",   32'(cnt), 32'(T_BLOQ * UM));
      chk("lock_mask0", 32'(bus_if.hifen_mask), 32'h00);
      chk("lock_erros0", 32'(bus_if.num_erros), 32'd0);
`ifdef SEGUNDOS_RESTANTES_EN
      chk("lock_seg_exit", 32'(bus_if.segundos_rest), 32'd0);
`endif
      tick();
      if (bus_if.fim_bloqueio === 1'b1) nfim++;
      chk("fim_pulses", 32'(nfim), 32'd1);

      // senha_ok clears the count; ok+erro together counts as an error.
      for (int i = 0; i < 2; i++) begin
         send(1'b0, 1'b1);
         wait_idle(5000, cnt);
      end
      chk("erros_2", 32'(bus_if.num_erros), 32'd2);
      send(1'b1, 1'b0);
      chk("ok_erros", 32'(bus_if.num_erros),  32'd0);
      chk("ok_mask",  32'(bus_if.hifen_mask), 32'h00);
      send(1'b1, 1'b1);
      chk("both_erros",   32'(bus_if.num_erros),  32'd1);
      chk("both_teclado", 32'(bus_if.teclado_en), 32'd0);
      wait_idle(5000, cnt);

      // Reach lockout again, then asynchronous reset 500 cycles in.
      for (int i = 0; i < 3; i++) begin
         send(1'b0, 1'b1);
         wait_idle(5000, cnt);
      end
      send(1'b0, 1'b1);
      chk("lock2_bloq", 32'(bus_if.bloqueado), 32'd1);
      repeat (500) tick();
      #1 rst = 1'b1;
      #1;
      chk("arst_teclado", 32'(bus_if.teclado_en), 32'd1);
      chk("arst_bloq",    32'(bus_if.bloqueado),  32'd0);
      chk("arst_inop",    32'(bus_if.inoperante), 32'd0);
      chk("arst_mask",    32'(bus_if.hifen_mask), 32'h00);
      chk("arst_erros",   32'(bus_if.num_erros),  32'd0);
`ifdef SEGUNDOS_RESTANTES_EN
      chk("arst_seg",     32'(bus_if.segundos_rest), 32'd0);
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // Random pulses, including ones landing inside penalties and lockouts.
      for (int c = 0; c < 15000; c++) begin
         bus_if.senha_erro = ($urandom_range(0, 99) == 0);
         bus_if.senha_ok   = ($urandom_range(0, 149) == 0);
         tick();
      end
      bus_if.senha_erro = 1'b0;
      bus_if.senha_ok   = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
